// File: rtl/axi4_full_rd_pkg.sv
// Shared AXI4 encodings used by the read master: burst types, response codes and beat size.
`timescale 1ns/1ps
package axi4_full_rd_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

endpackage

// File: rtl/axi4_full_rd.sv
// AXI4-Full read master: takes one INCR burst request at a time, issues AR, streams R beats
// to the user and reports the first error response plus any rlast/beat-count disagreement.
`timescale 1ns/1ps
module axi4_full_rd
   import axi4_full_rd_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic        m_aclk,
   input  logic        m_arst,
   // user request
   input  logic [31:0] rd_addr,
   input  logic [7:0]  rd_len,
   input  logic        rd_valid,
   output logic        rd_ready,
   // user beat stream
   output logic [31:0] rd_data,
   output logic        rd_data_valid,
   output logic        rd_data_last,
   input  logic        rd_data_ready,
   // completion
   output logic        rd_done,
   output logic [1:0]  rd_resp,
   output logic        rd_len_err,
   // AR channel
   output logic [3:0]  m_axi_arid,
   output logic [31:0] m_axi_araddr,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic        m_axi_arlock,
   output logic [3:0]  m_axi_arcache,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arqos,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   // R channel
   input  logic [3:0]  m_axi_rid,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   // debug
   output logic [3:0]  dbg_state
);

   // Handshake rule on every channel: a transfer happens on a rising edge where valid and
   // ready are both high; the valid side holds its payload stable until that edge.

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_RD_ADDR = 4'b0010,
      ST_RD_DATA = 4'b0100,
      ST_RD_DONE = 4'b1000
   } rd_state_t;

   rd_state_t   state;
   logic [29:0] addr_q;
   logic [7:0]  len_q;
   logic [7:0]  beat_cnt;
   logic [1:0]  resp_q;
   logic        len_err_q;

   logic        beat;
   logic        last_beat;
   logic        unused_ok;

   // rid is deliberately not checked and the byte offset bits are dropped.
   assign unused_ok = ^{m_axi_rid, rd_addr[1:0]};

   assign beat      = (state == ST_RD_DATA) && m_axi_rvalid && rd_data_ready;
   assign last_beat = (beat_cnt == len_q);

   always_ff @(posedge m_aclk) begin
      if (m_arst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         resp_q    <= AXI_RESP_OKAY;
         len_err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rd_valid) begin
                  addr_q    <= rd_addr[31:2];
                  len_q     <= rd_len;
                  beat_cnt  <= '0;
                  resp_q    <= AXI_RESP_OKAY;
                  len_err_q <= 1'b0;
                  state     <= ST_RD_ADDR;
               end
            end
            ST_RD_ADDR: begin
               if (m_axi_arready) state <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  // only the first non-OKAY response of the burst is kept
                  if (m_axi_rresp != AXI_RESP_OKAY && resp_q == AXI_RESP_OKAY)
                     resp_q <= m_axi_rresp;
                  // whichever comes first, slave rlast or our own count, ends the burst
                  if (m_axi_rlast || last_beat) begin
                     len_err_q <= (m_axi_rlast != last_beat);
                     state     <= ST_RD_DONE;
                  end
               end
            end
            ST_RD_DONE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   assign rd_ready      = (state == ST_IDLE);
   assign rd_done       = (state == ST_RD_DONE);
   assign rd_resp       = resp_q;
   assign rd_len_err    = len_err_q;

   assign rd_data       = m_axi_rdata;
   assign rd_data_valid = (state == ST_RD_DATA) && m_axi_rvalid;
   assign rd_data_last  = rd_data_valid && last_beat;
   assign m_axi_rready  = (state == ST_RD_DATA) && rd_data_ready;

   assign m_axi_arvalid = (state == ST_RD_ADDR);
   assign m_axi_araddr  = (state == ST_RD_ADDR) ? {addr_q, 2'b00} : 32'h0;
   assign m_axi_arlen   = (state == ST_RD_ADDR) ? len_q : 8'h0;
   assign m_axi_arid    = AXI_ID;
   assign m_axi_arsize  = AXI_SIZE_4B;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;

   assign dbg_state     = state;

endmodule

// File: tb/tb_axi4_full_rd.sv
// Bench for axi4_full_rd: directed bursts for the called-out corner cases, then random bursts
// served by a slave model and checked against an expected-beat queue.
`timescale 1ns/1ps
module tb_axi4_full_rd;

   logic        m_aclk;
   logic        m_arst;
   logic [31:0] rd_addr;
   logic [7:0]  rd_len;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic        rd_data_last;
   logic        rd_data_ready;
   logic        rd_done;
   logic [1:0]  rd_resp;
   logic        rd_len_err;
   logic [3:0]  m_axi_arid;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arlock;
   logic [3:0]  m_axi_arcache;
   logic [2:0]  m_axi_arprot;
   logic [3:0]  m_axi_arqos;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [3:0]  m_axi_rid;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [3:0]  dbg_state;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] exp_q[$];
   logic        exp_last_q[$];
   logic [1:0]  resp_a [256];

   axi4_full_rd dut (
      .m_aclk        (m_aclk),
      .m_arst        (m_arst),
      .rd_addr       (rd_addr),
      .rd_len        (rd_len),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .rd_data_last  (rd_data_last),
      .rd_data_ready (rd_data_ready),
      .rd_done       (rd_done),
      .rd_resp       (rd_resp),
      .rd_len_err    (rd_len_err),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arqos   (m_axi_arqos),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial m_aclk = 1'b0;
   always #5 m_aclk = ~m_aclk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Every cycle starts 1 time unit after the rising edge.
   task automatic tick();
      @(posedge m_aclk);
      #1;
   endtask

   // Slave memory contents: arbitrary address hash with one fixed word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5A5A, ~a[31:16] ^ a[15:0]};
   endfunction

   task automatic clear_resp();
      for (int i = 0; i < 256; i++) resp_a[i] = 2'b00;
   endtask

   // ---------------- driver + slave model ----------------
   // rl_pos: beat index at which the slave asserts rlast (>len means never).
   // ar_wait < 0 picks a random arready delay; stall_at stalls the user for 2 cycles at that beat.
   // rst_at >= 0 pulses reset in place of that beat; keep leaves rd_valid high after accept.
   task automatic run_burst(input logic [31:0] addr, input int len, input int rl_pos,
                            input int ar_wait, input int stall_at, input int rst_at,
                            input bit keep);
      logic [31:0] base;
      logic [1:0]  exp_resp;
      bit          exp_len_err;
      int          n_exp, waits, i, stall_cnt, cyc;
      bit          took;
      logic        got_last;

      // reference model: which beats the user must see and the final status
      base        = {addr[31:2], 2'b00};
      n_exp       = ((rl_pos < len) ? rl_pos : len) + 1;
      exp_resp    = 2'b00;
      exp_len_err = (rl_pos != len);
      for (int k = 0; k < n_exp; k++) begin
         exp_q.push_back(mem_word(base + 32'(4 * k)));
         exp_last_q.push_back(k == len);
         if (exp_resp == 2'b00) exp_resp = resp_a[k];
      end

      // request
      rd_addr  = addr;
      rd_len   = 8'(len);
      rd_valid = 1'b1;
      waits    = 0;
      #1;
      while (!rd_ready && waits < 10) begin
         tick();
         waits++;
      end
      check("accept_wait", 32'(waits), 32'd0);
      tick();
      if (!keep) rd_valid = 1'b0;

      // AR channel
      if (ar_wait < 0) ar_wait = $urandom_range(0, 3);
      for (int w = 0; w <= ar_wait; w++) begin
         m_axi_arready = (w == ar_wait);
         #1;
         check("arvalid", 32'(m_axi_arvalid), 32'd1);
         check("araddr", m_axi_araddr, base);
         check("arlen", 32'(m_axi_arlen), 32'(len));
         check("rd_ready_busy", 32'(rd_ready), 32'd0);
         if (w == ar_wait)
            check("ar_static",
                  32'({m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
                       m_axi_arprot, m_axi_arqos, m_axi_arid}),
                  32'({3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0}));
         tick();
      end
      m_axi_arready = 1'b0;

      // R channel
      i         = 0;
      stall_cnt = 0;
      cyc       = 0;
      took      = 1'b0;
      while (exp_q.size() > 0) begin
         if (i == rst_at) begin
            m_axi_rvalid = 1'b0;
            m_arst       = 1'b1;
            tick();
            m_arst = 1'b0;
            #1;
            check("rst_state", 32'(dbg_state), 32'h1);
            check("rst_rd_ready", 32'(rd_ready), 32'd1);
            check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
            check("rst_rready", 32'(m_axi_rready), 32'd0);
            check("rst_resp", 32'({rd_resp, rd_len_err}), 32'd0);
            for (int k = 0; k < 3; k++) begin
               check("rst_no_done", 32'(rd_done), 32'd0);
               tick();
            end
            exp_q.delete();
            exp_last_q.delete();
            return;
         end
         m_axi_rvalid  = ($urandom_range(0, 3) != 0);
         rd_data_ready = ($urandom_range(0, 3) != 0);
         if (i == stall_at && stall_cnt < 2) begin
            m_axi_rvalid  = 1'b1;
            rd_data_ready = 1'b0;
            stall_cnt++;
         end
         m_axi_rdata = mem_word(base + 32'(4 * i));
         m_axi_rresp = resp_a[i[7:0]];
         m_axi_rlast = (i == rl_pos);
         m_axi_rid   = 4'($urandom_range(0, 15));
         #1;
         check("rready", 32'(m_axi_rready), 32'(rd_data_ready));
         check("rd_data_valid", 32'(rd_data_valid), 32'(m_axi_rvalid));
         check("ar_idle", {m_axi_araddr[31:1], m_axi_arvalid}, 32'd0);
         check("done_early", 32'(rd_done), 32'd0);
         if (m_axi_rvalid && rd_data_ready) begin
            got_last = rd_data_last;
            check("rd_data", rd_data, exp_q.pop_front());
            check("rd_data_last", 32'(got_last), 32'(exp_last_q.pop_front()));
            i++;
         end
         tick();
         cyc++;
         if (cyc > 4000) begin
            check("data_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            exp_last_q.delete();
            took = 1'b1;
         end
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      if (took) return;

      // completion
      #1;
      check("rd_done", 32'(rd_done), 32'd1);
      check("done_rd_ready", 32'(rd_ready), 32'd0);
      check("rd_resp", 32'(rd_resp), 32'(exp_resp));
      check("rd_len_err", 32'(rd_len_err), 32'(exp_len_err));
      tick();
      check("done_pulse", 32'(rd_done), 32'd0);
      check("idle_rd_ready", 32'(rd_ready), 32'd1);
      check("resp_hold", 32'({rd_resp, rd_len_err}), 32'({exp_resp, exp_len_err}));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int len, rl;
      logic [31:0] a;

      m_arst        = 1'b1;
      rd_addr       = '0;
      rd_len        = '0;
      rd_valid      = 1'b0;
      rd_data_ready = 1'b1;
      m_axi_arready = 1'b0;
      m_axi_rid     = '0;
      m_axi_rdata   = '0;
      m_axi_rresp   = '0;
      m_axi_rlast   = 1'b0;
      m_axi_rvalid  = 1'b0;
      clear_resp();
      repeat (3) tick();
      m_arst = 1'b0;
      #1;
      check("reset_state", 32'(dbg_state), 32'h1);
      check("reset_rd_ready", 32'(rd_ready), 32'd1);
      check("reset_outs", 32'({m_axi_arvalid, m_axi_rready, rd_data_valid, rd_data_last,
                               rd_done, rd_len_err, rd_resp}), 32'd0);
      tick();

      // single beat
      run_burst(32'h0000_1000, 0, 0, 2, -1, -1, 1'b0);
      // burst with unaligned address and user stall
      run_burst(32'h0000_2003, 3, 3, -1, 1, -1, 1'b0);
      // error responses, first one sticks
      resp_a[1] = 2'b10;
      resp_a[2] = 2'b11;
      run_burst(32'h0000_3000, 2, 2, -1, -1, -1, 1'b0);
      clear_resp();
      // early rlast, then missing rlast
      run_burst(32'h0000_4000, 3, 1, -1, -1, -1, 1'b0);
      run_burst(32'h0000_5000, 2, 255, -1, -1, -1, 1'b0);
      // reset in the middle of a burst, then a clean burst
      run_burst(32'h0000_6000, 3, 3, -1, -1, 1, 1'b0);
      run_burst(32'h0000_6100, 1, 1, -1, -1, -1, 1'b0);
      // back-to-back with rd_valid held
      run_burst(32'h0000_7000, 0, 0, -1, -1, -1, 1'b1);
      run_burst(32'h0000_7040, 0, 0, -1, -1, -1, 1'b0);
      // longest burst
      run_burst(32'h0001_0000, 255, 255, -1, -1, -1, 1'b0);

      // random bursts
      for (int n = 0; n < 25; n++) begin
         len = $urandom_range(0, 15);
         rl  = len;
         if ($urandom_range(0, 4) == 0) rl = $urandom_range(0, len + 1);
         if (rl > len) rl = 255;
         for (int k = 0; k < 256; k++)
            resp_a[k] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         a = $urandom_range(0, 32'h00FF_FFFF);
         run_burst(a, len, rl, -1, -1, -1, 1'($urandom_range(0, 1)));
      end
      rd_valid = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
